// File: rtl/acq_trigger_pkg.sv
// -----------------------------------------------------------------------------
// acq_trigger_pkg
// Shared definitions for the acquisition trigger slice: default buffer and
// synchroniser sizes, the trigger FSM state enumeration, the trig_src
// encodings and a helper that derives the holdoff length from the buffer size.
// -----------------------------------------------------------------------------
package acq_trigger_pkg;

   // log2 of the acquisition buffer depth.
   localparam int unsigned DEF_BRAM_WIDTH    = 13;
   // Flops between the asynchronous trigger pin and the edge detector.
   localparam int unsigned DEF_SYNC_STAGES   = 2;
   localparam int unsigned DEF_TIMEOUT_WIDTH = 32;
   localparam int unsigned TRIG_COUNT_WIDTH  = 32;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_HOLDOFF = 2'd2
   } acq_state_e;

   typedef enum logic [1:0] {
      SRC_SOFT = 2'b00,   // soft_trig strobe
      SRC_EXT  = 2'b01,   // selected edge of synchronised trig_in
      SRC_IMM  = 2'b10,   // fire on the first ARMED clock
      SRC_RSVD = 2'b11    // reserved: never triggers
   } trig_src_e;

   // Holdoff spans address alignment plus one full buffer write, i.e. twice
   // the buffer depth.
   function automatic int unsigned holdoff_len(input int unsigned bram_width);
      return 32'd1 << (bram_width + 1);
   endfunction

endpackage

// File: rtl/trig_sync.sv
// -----------------------------------------------------------------------------
// trig_sync
// Brings the asynchronous external trigger into the clk domain through a
// SYNC_STAGES-deep flop chain (minimum 2) and compares consecutive synchronised
// samples to produce registered single-cycle rise/fall pulses.
//
// Ports
//   clk     in   system clock
//   rst     in   synchronous active-high reset, clears the whole chain
//   trig_i  in   asynchronous trigger pin
//   rise_o  out  one-clock pulse on a 0->1 transition of the synchronised pin
//   fall_o  out  one-clock pulse on a 1->0 transition of the synchronised pin
// -----------------------------------------------------------------------------
module trig_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic trig_i,
   output logic rise_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   rise_q;
   logic                   fall_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge value of its neighbour; blocking here would collapse the
   // synchroniser chain into a single stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], trig_i};
         prev_q <= sync_q[SYNC_STAGES-1];
         rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
         fall_q <= ~sync_q[SYNC_STAGES-1] & prev_q;
      end
   end

   assign rise_o = rise_q;
   assign fall_o = fall_q;

endmodule

// File: rtl/acq_trigger.sv
// -----------------------------------------------------------------------------
// acq_trigger
// Acquisition trigger controller. From IDLE an arm request enters ARMED, where
// a trigger event (software strobe, external edge, immediate, or timeout
// expiry) issues a one-clock start_acq pulse and enters HOLDOFF. HOLDOFF covers
// the start_acq clock followed by a window of 2^(BRAM_WIDTH+1) clocks in which
// all triggers are ignored; it then re-arms (continuous) or returns to IDLE.
// abort returns to IDLE from any state and beats every other request.
//
// Ports
//   clk, rst     in   system clock, synchronous active-high reset
//   arm          in   arm request (only honoured in IDLE)
//   abort        in   return to IDLE
//   soft_trig    in   software trigger strobe
//   trig_in      in   asynchronous external trigger
//   trig_src     in   trigger source select (see trig_src_e)
//   trig_edge    in   0 rising, 1 falling external edge
//   continuous   in   re-arm automatically after holdoff
//   timeout_en   in   enable forced trigger after `timeout` ARMED clocks
//   timeout      in   forced-trigger delay
//   start_acq    out  one-clock acquisition start pulse
//   armed        out  FSM in ARMED
//   busy         out  FSM in ARMED or HOLDOFF
//   timed_out    out  sticky: last acquisition was forced by the timeout
//   trig_count   out  number of start_acq pulses, wrapping
// -----------------------------------------------------------------------------
module acq_trigger
   import acq_trigger_pkg::*;
#(
   parameter int unsigned BRAM_WIDTH    = DEF_BRAM_WIDTH,
   parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
   parameter int unsigned TIMEOUT_WIDTH = DEF_TIMEOUT_WIDTH
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        arm,
   input  logic                        abort,
   input  logic                        soft_trig,
   input  logic                        trig_in,
   input  logic [1:0]                  trig_src,
   input  logic                        trig_edge,
   input  logic                        continuous,
   input  logic                        timeout_en,
   input  logic [TIMEOUT_WIDTH-1:0]    timeout,
   output logic                        start_acq,
   output logic                        armed,
   output logic                        busy,
   output logic                        timed_out,
   output logic [TRIG_COUNT_WIDTH-1:0] trig_count
);

   localparam int unsigned      HOLD_W    = BRAM_WIDTH + 2;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(holdoff_len(BRAM_WIDTH));

   acq_state_e                  state_q;
   logic                        start_acq_q;
   logic                        armed_q;
   logic                        busy_q;
   logic                        timed_out_q;
   logic [TRIG_COUNT_WIDTH-1:0] trig_count_q;
   logic [TIMEOUT_WIDTH-1:0]    tmo_cnt_q;
   logic [HOLD_W-1:0]           hold_cnt_q;

   logic                        ext_rise;
   logic                        ext_fall;
   logic                        tmo_hit;
   logic                        trig_event;

   trig_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_trig_sync (
      .clk    (clk),
      .rst    (rst),
      .trig_i (trig_in),
      .rise_o (ext_rise),
      .fall_o (ext_fall)
   );

   // Trigger qualification. Only consulted while ARMED, so the timeout compare
   // needs no state gating here.
   // NOTE: every signal driven in this always_comb gets a value before any
   // branch, so no path can leave one unassigned and infer a latch.
   always_comb begin
      tmo_hit    = timeout_en && (tmo_cnt_q == timeout);
      trig_event = tmo_hit;
      case (trig_src_e'(trig_src))
         SRC_SOFT: trig_event = trig_event | soft_trig;
         SRC_EXT:  trig_event = trig_event | (trig_edge ? ext_fall : ext_rise);
         SRC_IMM:  trig_event = 1'b1;
         default:  trig_event = tmo_hit;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         start_acq_q  <= 1'b0;
         armed_q      <= 1'b0;
         busy_q       <= 1'b0;
         timed_out_q  <= 1'b0;
         trig_count_q <= '0;
         tmo_cnt_q    <= '0;
         hold_cnt_q   <= '0;
      end else begin
         start_acq_q <= 1'b0;
         if (abort) begin
            state_q <= ST_IDLE;
            armed_q <= 1'b0;
            busy_q  <= 1'b0;
         end else begin
            unique case (state_q)
               ST_IDLE: begin
                  if (arm) begin
                     state_q     <= ST_ARMED;
                     armed_q     <= 1'b1;
                     busy_q      <= 1'b1;
                     tmo_cnt_q   <= '0;
                     timed_out_q <= 1'b0;
                  end
               end
               ST_ARMED: begin
                  if (trig_event) begin
                     state_q      <= ST_HOLDOFF;
                     armed_q      <= 1'b0;
                     start_acq_q  <= 1'b1;
                     trig_count_q <= trig_count_q + TRIG_COUNT_WIDTH'(1);
                     hold_cnt_q   <= '0;
                     if (tmo_hit) begin
                        timed_out_q <= 1'b1;
                     end
                  end else begin
                     tmo_cnt_q <= tmo_cnt_q + TIMEOUT_WIDTH'(1);
                  end
               end
               ST_HOLDOFF: begin
                  // Count 0 is the start_acq clock; the ignore window is the
                  // HOLD_LAST clocks that follow it.
                  if (hold_cnt_q == HOLD_LAST) begin
                     if (continuous) begin
                        state_q   <= ST_ARMED;
                        armed_q   <= 1'b1;
                        tmo_cnt_q <= '0;
                     end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                     end
                  end else begin
                     hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
                  end
               end
               default: begin
                  state_q <= ST_IDLE;
                  armed_q <= 1'b0;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign start_acq  = start_acq_q;
   assign armed      = armed_q;
   assign busy       = busy_q;
   assign timed_out  = timed_out_q;
   assign trig_count = trig_count_q;

endmodule

// File: tb/tb_acq_trigger.sv
// -----------------------------------------------------------------------------
// tb_acq_trigger
// Self-checking bench for acq_trigger (BRAM_WIDTH=4, SYNC_STAGES=2). A
// timestamp-based reference model predicts every output each clock; directed
// scenarios add explicit latency/period checks, followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_acq_trigger;

   localparam int unsigned BW   = 4;
   localparam int unsigned SS   = 2;
   localparam int unsigned TW   = 32;
   localparam longint      HOLD = 32;   // 2^(BW+1)

   logic          clk = 1'b0;
   logic          rst, arm, abort, soft_trig, trig_in, trig_edge, continuous, timeout_en;
   logic [1:0]    trig_src;
   logic [TW-1:0] timeout;
   logic          start_acq, armed, busy, timed_out;
   logic [31:0]   trig_count;

   acq_trigger #(
      .BRAM_WIDTH    (BW),
      .SYNC_STAGES   (SS),
      .TIMEOUT_WIDTH (TW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .arm        (arm),
      .abort      (abort),
      .soft_trig  (soft_trig),
      .trig_in    (trig_in),
      .trig_src   (trig_src),
      .trig_edge  (trig_edge),
      .continuous (continuous),
      .timeout_en (timeout_en),
      .timeout    (timeout),
      .start_acq  (start_acq),
      .armed      (armed),
      .busy       (busy),
      .timed_out  (timed_out),
      .trig_count (trig_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   // ---------------- reference model (timestamps, not counters) -------------
   typedef enum {PH_IDLE, PH_ARMED, PH_HOLD} phase_e;
   phase_e      m_phase  = PH_IDLE;
   longint      cyc      = 0;
   longint      armed_at = 0;   // edge at which ARMED was entered
   longint      hold_end = 0;   // edge at which HOLDOFF is left
   logic [3:0]  hist     = '0;  // hist[k] = trig_in sampled k+1 edges ago
   logic        m_pulse  = 1'b0;
   logic        m_tout   = 1'b0;
   logic [31:0] m_count  = '0;

   task automatic model_step();
      logic rise, fall, hit_t, ev;
      cyc++;
      m_pulse = 1'b0;
      // The controller sees an external edge 3 edges after the pin sample
      // that completes it (2 sync flops + registered edge pulse).
      rise = hist[2] & ~hist[3];
      fall = ~hist[2] & hist[3];
      if (rst) begin
         m_phase = PH_IDLE;
         m_tout  = 1'b0;
         m_count = '0;
         hist    = '0;
      end else begin
         hist = {hist[2:0], trig_in};
         if (abort) begin
            m_phase = PH_IDLE;
         end else if (m_phase == PH_IDLE) begin
            if (arm) begin
               m_phase  = PH_ARMED;
               armed_at = cyc;
               m_tout   = 1'b0;
            end
         end else if (m_phase == PH_ARMED) begin
            hit_t = timeout_en && ((cyc - armed_at - 1) == longint'(timeout));
            ev    = hit_t || (trig_src == 2'd2) || (trig_src == 2'd0 && soft_trig) ||
                    (trig_src == 2'd1 && (trig_edge ? fall : rise));
            if (ev) begin
               m_pulse  = 1'b1;
               m_count  = m_count + 32'd1;
               m_phase  = PH_HOLD;
               hold_end = cyc + HOLD + 1;
               if (hit_t) m_tout = 1'b1;
            end
         end else if (cyc == hold_end) begin
            m_phase  = continuous ? PH_ARMED : PH_IDLE;
            armed_at = cyc;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("start_acq", {31'd0, start_acq}, {31'd0, m_pulse});
      check("armed", {31'd0, armed}, {31'd0, m_phase == PH_ARMED});
      check("busy", {31'd0, busy}, {31'd0, m_phase != PH_IDLE});
      check("timed_out", {31'd0, timed_out}, {31'd0, m_tout});
      check("trig_count", trig_count, m_count);
   endtask

   task automatic pulse_arm();
      arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 80 && busy; i++) tick();
      check(tag, {31'd0, busy}, 32'd0);
   endtask

   // Ticks until start_acq is seen (bounded); returns the tick count.
   task automatic ticks_to_pulse(input int limit, output int n);
      n = 0;
      for (int i = 0; i < limit; i++) begin
         tick();
         n++;
         if (start_acq) break;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      rst = 1'b1; arm = 1'b0; abort = 1'b0; soft_trig = 1'b0; trig_in = 1'b0;
      trig_src = 2'd0; trig_edge = 1'b0; continuous = 1'b0; timeout_en = 1'b0;
      timeout = '0;
      @(negedge clk);
      tick(); tick();
      rst = 1'b0;
      tick();
      check("reset_count", trig_count, 32'd0);

      // Software trigger: pulse the clock after soft_trig, 33 busy clocks.
      trig_src = 2'd0;
      pulse_arm();
      repeat (4) tick();
      soft_trig = 1'b1;
      tick();
      soft_trig = 1'b0;
      check("soft_latency", {31'd0, start_acq}, 32'd1);
      n = 1;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (!busy) break;
         n++;
      end
      check("soft_busy_len", n, 33);
      check("soft_count", trig_count, 32'd1);

      // External rising edge: 4 clocks pin-to-pulse; edges in HOLDOFF ignored.
      trig_src = 2'd1; trig_edge = 1'b0;
      pulse_arm();
      repeat (3) tick();
      trig_in = 1'b1;
      ticks_to_pulse(10, n);
      check("ext_latency", n, 4);
      repeat (3) tick();
      trig_in = 1'b0;
      repeat (6) tick();
      trig_in = 1'b1;
      repeat (6) tick();
      wait_idle("ext_idle");
      pulse_arm();
      repeat (3) tick();
      trig_in = 1'b0;                       // falling edge, rising selected
      repeat (8) tick();
      check("fall_ignored", {31'd0, armed}, 32'd1);
      abort = 1'b1; tick(); abort = 1'b0;
      trig_in = 1'b1;                       // edge while IDLE
      repeat (6) tick();

      // Forced trigger after timeout=10.
      trig_src = 2'd3; timeout_en = 1'b1; timeout = 32'd10;
      pulse_arm();
      ticks_to_pulse(20, n);
      check("timeout_latency", n, 11);
      check("timed_out_set", {31'd0, timed_out}, 32'd1);
      wait_idle("timeout_idle");
      pulse_arm();
      check("timed_out_clear", {31'd0, timed_out}, 32'd0);
      abort = 1'b1; tick(); abort = 1'b0;
      timeout_en = 1'b0;

      // Continuous immediate triggering with trig_count wrap.
      force dut.trig_count_q = 32'hFFFF_FFFF;
      #1;
      release dut.trig_count_q;
      m_count = 32'hFFFF_FFFF;
      check("preload", trig_count, 32'hFFFF_FFFF);
      trig_src = 2'd2; continuous = 1'b1;
      pulse_arm();
      tick();
      check("imm_pulse", {31'd0, start_acq}, 32'd1);
      check("count_wrap", trig_count, 32'd0);
      ticks_to_pulse(50, n);
      check("cont_period", n, 34);
      check("count_after_wrap", trig_count, 32'd1);
      continuous = 1'b0;
      wait_idle("cont_idle");

      // abort beats a simultaneous soft trigger.
      trig_src = 2'd0;
      pulse_arm();
      tick();
      soft_trig = 1'b1; abort = 1'b1;
      tick();
      soft_trig = 1'b0; abort = 1'b0;
      check("abort_no_pulse", {31'd0, start_acq}, 32'd0);
      check("abort_idle", {31'd0, busy}, 32'd0);

      // rst in the middle of HOLDOFF.
      pulse_arm();
      soft_trig = 1'b1; tick(); soft_trig = 1'b0;
      repeat (5) tick();
      check("holdoff_busy", {31'd0, busy}, 32'd1);
      rst = 1'b1; tick(); rst = 1'b0;
      check("rst_outputs", {28'd0, start_acq, armed, busy, timed_out}, 32'd0);
      check("rst_count", trig_count, 32'd0);

      // Randomized traffic checked cycle by cycle against the model.
      for (int i = 0; i < 4000; i++) begin
         if (i % 250 == 0) begin
            trig_src   = 2'($urandom_range(0, 3));
            trig_edge  = 1'($urandom_range(0, 1));
            continuous = 1'($urandom_range(0, 1));
            timeout_en = 1'($urandom_range(0, 1));
            timeout    = TW'($urandom_range(0, 45));
         end
         arm       = ($urandom_range(0, 7) == 0);
         abort     = ($urandom_range(0, 79) == 0);
         soft_trig = ($urandom_range(0, 15) == 0);
         rst       = ($urandom_range(0, 599) == 0);
         if ($urandom_range(0, 5) == 0) trig_in = ~trig_in;
         tick();
      end
      arm = 1'b0; abort = 1'b0; soft_trig = 1'b0; rst = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/acq_trigger.md
ACQ_TRIGGER -- requirements
Module: acq_trigger

Interface
REQ-001 Parameter BRAM_WIDTH, 13, log2 of acquisition buffer depth; holdoff length is 2^(BRAM_WIDTH+1) clocks.
REQ-002 Parameter SYNC_STAGES, 2, flip-flop stages synchronising trig_in (minimum 2).
REQ-003 Parameter TIMEOUT_WIDTH, 32, width of timeout value and timeout counter.
REQ-004 Ports: clk input 1 system clock; rst input 1 synchronous active-high reset.
REQ-005 arm input 1 single-cycle request to arm; abort input 1 single-cycle request to return to IDLE.
REQ-006 soft_trig input 1 single-cycle software trigger; trig_in input 1 asynchronous external trigger.
REQ-007 trig_src input 2: 00 software, 01 external, 10 immediate (trigger on first ARMED cycle), 11 reserved, never triggers.
REQ-008 trig_edge input 1: 0 rising, 1 falling edge of synchronised trig_in.
REQ-009 continuous input 1: after holdoff, re-arm automatically instead of returning to IDLE.
REQ-010 timeout_en input 1; timeout input TIMEOUT_WIDTH, forced-trigger delay in ARMED clocks.
REQ-011 start_acq output 1: single-cycle pulse consumed by the downstream write-enable stage.
REQ-012 armed output 1 high in ARMED; busy output 1 high in ARMED or HOLDOFF; timed_out output 1 sticky forced-trigger flag; trig_count output 32 count of start_acq pulses.

Function
REQ-013 FSM states IDLE, ARMED, HOLDOFF; one-hot or binary encoding is free.
REQ-014 IDLE -> ARMED on arm; arm in ARMED or HOLDOFF is ignored.
REQ-015 ARMED -> HOLDOFF on a trigger event; start_acq is high for exactly one clock, the clock after the event is detected.
REQ-016 Trigger event: trig_src=00 soft_trig high; 01 selected edge on synchronised trig_in; 10 first clock in ARMED; or timeout expiry.
REQ-017 Edge detection compares consecutive synchronised samples; only edges whose second sample falls in ARMED count; edges are never queued.
REQ-018 External latency: trig_in change to start_acq high = SYNC_STAGES+2 clocks.
REQ-019 Timeout counter clears on ARMED entry, increments each ARMED clock; when timeout_en=1 and count equals timeout, forced trigger fires; timeout=0 fires on first ARMED clock.
REQ-020 Forced trigger sets timed_out; timed_out clears on next accepted arm.
REQ-021 HOLDOFF lasts exactly 2^(BRAM_WIDTH+1) clocks, covering address alignment plus one full buffer write; all triggers ignored.
REQ-022 HOLDOFF end -> ARMED if continuous=1 (timeout counter cleared), else IDLE.
REQ-023 abort in any state -> IDLE next clock; abort wins over simultaneous trigger (no start_acq), over arm, and over holdoff expiry.
REQ-024 trig_count increments with each start_acq, wraps 2^32-1 -> 0.
REQ-025 Inputs other than trig_in are synchronous to clk.

Reset
REQ-026 rst forces IDLE; start_acq, armed, busy, timed_out, trig_count, holdoff and timeout counters to 0; synchroniser flops to 0.
REQ-027 rst mid-HOLDOFF or mid-ARMED aborts without a start_acq pulse; rst has priority over all inputs.

Structure
REQ-028 State enumeration and trig_src encodings live in the shared acquisition package, with BRAM-width defaults.
REQ-029 Synchroniser plus edge detector is a sub-module, trig_sync (SYNC_STAGES parameter, outputs rise and fall pulses).

Verification (BRAM_WIDTH=4, SYNC_STAGES=2, holdoff 32 clocks)
REQ-030 trig_src=00, arm, soft_trig 5 clocks later -> start_acq one clock later, busy 33 clocks, trig_count=1, then IDLE.
REQ-031 trig_src=01 rising, trig_in 0->1 in ARMED -> start_acq exactly 4 clocks after; falling edge and edges in HOLDOFF/IDLE -> no pulse.
REQ-032 timeout_en=1, timeout=10, no trigger -> start_acq 1 clock after 11th ARMED clock (count 10), timed_out=1; next arm clears it.
REQ-033 continuous=1, trig_src=10 -> start_acq every 34 clocks; trig_count preloaded to 0xFFFFFFFF wraps to 0.
REQ-034 abort same clock as soft_trig -> no start_acq, IDLE next clock; rst during HOLDOFF -> all outputs 0 next clock.
